// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered one-hot grant and encoded index.
// Define RR_ARB_TIMEOUT_EN to force release of a grant after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid
);

    // state | meaning
    // IDLE  | nobody owns the resource; arbitrate when enabled and requested
    // OWNED | grant_idx owns the resource until it drops its request (or times out)
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] win_idx;
    logic       win_found;
    logic       owner_drop;
    logic       hold_expired;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be in 2..255");
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                win_idx   = ptr + 3'(k);
                win_found = 1'b1;
            end
        end
    end

    assign owner_drop = ~req[grant_idx];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            ptr         <= 3'd0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable && win_found) begin
                        state       <= OWNED;
                        grant       <= 8'd1 << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt    <= 8'd0;
`endif
                    end
                end
                OWNED: begin
                    if (owner_drop || hold_expired) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 3'd1;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 8'h00;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural round-robin model.
module tb_rr_arbiter8;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner number (-1 = none), last owner, priority start, cycles held.
    int m_owner = -1;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_rel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_idx   = 0;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            m_rel = (req[m_owner] == 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
            if (!m_rel && m_held >= MAX_HOLD) m_rel = 1'b1;
`endif
            if (m_rel) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (enable && req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_idx   = m_owner;
                    m_held  = 1;
                end
            end
        end
    end

    logic [7:0] exp_grant;
    always @(negedge clk) begin
        exp_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        chk("model_grant", 32'(grant), 32'(exp_grant));
        chk("model_idx", 32'(grant_idx), 32'(m_idx));
        chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; enable = 1'b0; req = 8'h00;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(grant), 32'h00);
        chk("reset_idx", 32'(grant_idx), 32'h0);
        chk("reset_valid", 32'(grant_valid), 32'h0);
        #1 rst = 1'b0;

        // single requester
        @(negedge clk); #1 enable = 1'b1; req = 8'h20;
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'h20);
        chk("single_idx", 32'(grant_idx), 32'd5);
        chk("single_valid", 32'(grant_valid), 32'h1);
        #1 req = 8'h00;
        @(negedge clk);
        chk("single_release", 32'(grant), 32'h00);
        chk("single_idx_hold", 32'(grant_idx), 32'd5);

        // pointer priority: owner 6 releases, then 0 beats 6
        #1 req = 8'h40;
        @(negedge clk); chk("ptr_owner6", 32'(grant_idx), 32'd6);
        #1 req = 8'h00;
        @(negedge clk); chk("ptr_release6", 32'(grant), 32'h00);
        #1 req = 8'h41;
        @(negedge clk);
        chk("ptr_wrap_grant", 32'(grant), 32'h01);
        chk("ptr_wrap_idx", 32'(grant_idx), 32'd0);
        #1 req = 8'h00;
        @(negedge clk);

        // enable gating
        #1 enable = 1'b0; req = 8'h04;
        repeat (2) @(negedge clk);
        chk("en_gate", 32'(grant), 32'h00);
        #1 enable = 1'b1;
        @(negedge clk); chk("en_grant", 32'(grant), 32'h04);
        #1 enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_drop_keep", 32'(grant), 32'h04);
        #1 req = 8'h00; enable = 1'b1;
        @(negedge clk); chk("en_release", 32'(grant), 32'h00);

        // rotation with wrap, 3-cycle tenures
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0; req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            chk("rot_idx", 32'(grant_idx), 32'(t % 8));
            chk("rot_grant", 32'(grant), 32'(1 << (t % 8)));
            repeat (2) @(negedge clk);
            chk("rot_hold", 32'(grant), 32'(1 << (t % 8)));
            #1 req[t % 8] = 1'b0;
            @(negedge clk);
            chk("rot_gap", 32'(grant), 32'h00);
            #1 req = 8'hFF;
        end

        // async reset mid-grant
        @(negedge clk);
        chk("rst_pre_valid", 32'(grant_valid), 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_grant", 32'(grant), 32'h00);
        chk("rst_async_valid", 32'(grant_valid), 32'h0);
        chk("rst_async_idx", 32'(grant_idx), 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_first_grant", 32'(grant), 32'h01);

        // hold behaviour with two steady requesters
        #1 rst = 1'b1; req = 8'h00;
        @(negedge clk); #1 rst = 1'b0; req = 8'h03;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk); chk("tmo_idx0", 32'(grant), 32'h01);
        end
        @(negedge clk); chk("tmo_gap", 32'(grant), 32'h00);
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk); chk("tmo_idx1", 32'(grant), 32'h02);
        end
        @(negedge clk); chk("tmo_gap2", 32'(grant), 32'h00);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); chk("hold_forever", 32'(grant), 32'h01);
        end
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            enable = ($urandom_range(0, 9) != 0);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
